sprite_ram_loader: RTL and testbench

Write-side companion to the sprite address path. Accepts a stream of pixel words, packs them into a 64x64 sprite RAM in row-major order using the same `{row[5:0], col[5:0]}` address format the display-side lookup reads. It gates writes to a caller-supplied safe window (typically vertical blanking) so the display never reads a half-updated sprite. It sits between the host/UART byte source and the sprite RAM write port.

---
 rtl/sprite_ram_loader_if.sv | 29 ++
 rtl/sprite_ram_loader.sv | 132 +++++++++++++
 tb/tb_sprite_ram_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_loader_if.sv
// Sprite loader bus: pixel stream in, sprite RAM write port out, plus load control/status.
//   master : host side (drives start, wr_window, s_valid, s_data)
//   slave  : loader side (drives s_ready, we, waddr, wdata, busy, done, err)
interface sprite_ram_loader_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SIZE_LOG2 = 6
);
  logic                   start;
  logic                   wr_window;
  logic                   s_valid;
  logic [DATA_W-1:0]      s_data;
  logic                   s_ready;
  logic                   we;
  logic [2*SIZE_LOG2-1:0] waddr;
  logic [DATA_W-1:0]      wdata;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, wr_window, s_valid, s_data,
    input  s_ready, we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  start, wr_window, s_valid, s_data,
    output s_ready, we, waddr, wdata, busy, done, err
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: packs a pixel stream into a 2^SIZE_LOG2 x 2^SIZE_LOG2 sprite RAM in
// row-major order, addressing it as {row, col}. Writes only happen while wr_window is high,
// so the display side never reads a half-updated sprite.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - sprite_ram_loader_if.slave: start/wr_window/s_valid/s_data in,
//          s_ready/we/waddr/wdata/busy/done/err out
//
// Build option: define SPRITE_LOAD_CHECKSUM_EN to consume a trailing DATA_W-bit sum word after
// the last pixel and flag a mismatch on err. Without it err is tied 0.
module sprite_ram_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SIZE_LOG2 = 6
) (
  input logic              clk,
  input logic              rst,
  sprite_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e                 state_q;
  logic [SIZE_LOG2-1:0]   row_q;
  logic [SIZE_LOG2-1:0]   col_q;
  logic                   we_q;
  logic [2*SIZE_LOG2-1:0] waddr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]      acc_q;
  logic                   err_q;
`endif

  logic xfer;

  // Ready depends only on state and the window, never on s_valid.
  assign bus.s_ready = ((state_q == StLoad) || (state_q == StCheck)) && bus.wr_window;
  assign xfer        = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPRITE_LOAD_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
`ifdef SPRITE_LOAD_CHECKSUM_EN
            acc_q   <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        StLoad: begin
          if (xfer) begin
            we_q    <= 1'b1;
            waddr_q <= {row_q, col_q};
            wdata_q <= bus.s_data;
            col_q   <= col_q + 1'b1;
`ifdef SPRITE_LOAD_CHECKSUM_EN
            acc_q   <= acc_q + bus.s_data;
`endif
            if (&col_q) begin
              row_q <= row_q + 1'b1;
              // Last pixel: both counters wrap to 0 here.
              if (&row_q) begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
                state_q <= StCheck;
`else
                state_q <= StDone;
                done_q  <= 1'b1;
`endif
              end
            end
          end
        end
        StCheck: begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
          // Trailer word is compared, never written to RAM.
          if (xfer) begin
            err_q   <= (acc_q != bus.s_data);
            state_q <= StDone;
            done_q  <= 1'b1;
          end
`else
          state_q <= StIdle;
          busy_q  <= 1'b0;
`endif
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`ifdef SPRITE_LOAD_CHECKSUM_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader. A transaction-level model tracks the pixel index,
// running sum and expected per-cycle outputs; every cycle the DUT outputs are compared to it.
module tb_sprite_ram_loader;

  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MCheck = 2;
  localparam int MDone  = 3;
  localparam int NPix   = 4096;
  localparam int Budget = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_ram_loader_if #(.DATA_W(8), .SIZE_LOG2(6)) bus ();

  sprite_ram_loader #(.DATA_W(8), .SIZE_LOG2(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          m_state = MIdle;
  int          m_idx = 0;
  logic [7:0]  m_sum = 8'h00;
  logic        m_err = 1'b0;
  int          ld_writes = 0;
  int          ld_dones = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check the outputs after the edge.
  task automatic run_cycle(input logic v, input logic win, input logic [7:0] d, input logic st);
    logic       m_ready;
    logic       xfer;
    logic       exp_we;
    logic       exp_done;
    logic [11:0] exp_addr;
    logic [7:0] exp_data;
    bus.s_valid   = v;
    bus.wr_window = win;
    bus.s_data    = d;
    bus.start     = st;
    #1;
    m_ready = ((m_state == MLoad) || (m_state == MCheck)) && win;
    chk("s_ready", 32'(bus.s_ready), 32'(m_ready));
    xfer     = v && m_ready;
    exp_we   = 1'b0;
    exp_done = 1'b0;
    exp_addr = 12'h000;
    exp_data = 8'h00;
    case (m_state)
      MIdle: if (st) begin
        m_state = MLoad;
        m_idx   = 0;
        m_sum   = 8'h00;
        m_err   = 1'b0;
      end
      MLoad: if (xfer) begin
        exp_we   = 1'b1;
        exp_addr = m_idx[11:0];
        exp_data = d;
        m_sum    = m_sum + d;
        m_idx++;
        if (m_idx == NPix) begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
          m_state = MCheck;
`else
          m_state  = MDone;
          exp_done = 1'b1;
`endif
        end
      end
      MCheck: if (xfer) begin
        m_err    = (m_sum != d);
        m_state  = MDone;
        exp_done = 1'b1;
      end
      default: m_state = MIdle;
    endcase
    @(posedge clk);
    #1;
    chk("we", 32'(bus.we), 32'(exp_we));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("busy", 32'(bus.busy), 32'(m_state != MIdle));
    chk("err", 32'(bus.err), 32'(m_err));
    if (exp_we) begin
      chk("waddr", 32'(bus.waddr), 32'(exp_addr));
      chk("wdata", 32'(bus.wdata), 32'(exp_data));
    end
    if (bus.we === 1'b1) ld_writes++;
    if (bus.done === 1'b1) ld_dones++;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.s_valid   = 1'b1;
    bus.wr_window = 1'b1;
    bus.s_data    = 8'hA5;
    bus.start     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    m_state = MIdle;
    m_idx   = 0;
    m_sum   = 8'h00;
    m_err   = 1'b0;
  endtask

  // mode 0: data = index, window stall after 0x07F, start pulse at pixel 2000
  // mode 1: random valid/window/data/start
  // mode 2: all pixels 0x01 with the given trailer (plus the same stall and start pulse)
  task automatic do_load(input int mode, input logic [7:0] trailer, input string name);
    int         cyc;
    int         stall;
    bit         pulsed;
    logic       v;
    logic       win;
    logic       st;
    logic [7:0] d;
    ld_writes = 0;
    ld_dones  = 0;
    stall     = 0;
    pulsed    = 1'b0;
    run_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cyc = 0;
    while (m_state != MIdle && cyc < Budget) begin
      v   = 1'b1;
      win = 1'b1;
      st  = 1'b0;
      d   = m_idx[7:0];
      if (mode == 1) begin
        v   = ($urandom_range(0, 3) != 0);
        win = ($urandom_range(0, 7) != 0);
        d   = 8'($urandom);
        st  = ($urandom_range(0, 63) == 0);
      end else begin
        if (mode == 2) d = 8'h01;
        if (m_idx == 128 && stall < 10) begin
          win = 1'b0;
          stall++;
        end
        if (m_idx == 2000 && !pulsed) begin
          st     = 1'b1;
          pulsed = 1'b1;
        end
      end
      if (m_state == MCheck) begin
        if (mode == 2) d = trailer;
        else if (mode == 1 && $urandom_range(0, 1) == 0) d = 8'($urandom);
        else d = m_sum;
      end
      run_cycle(v, win, d, st);
      cyc++;
    end
    chk({name, "_timeout"}, 32'(cyc < Budget), 32'd1);
    chk({name, "_writes"}, 32'(ld_writes), 32'(NPix));
    chk({name, "_dones"}, 32'(ld_dones), 32'd1);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.wr_window = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Reset in the middle of a load.
    run_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 300 && m_idx < 100; i++) run_cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    chk("midload_count", 32'(m_idx), 32'd100);
    apply_reset();

    // Full directed load after the reset must restart at address 0.
    do_load(0, 8'h00, "full");

    // Randomized load.
    do_load(1, 8'h00, "rand");

`ifdef SPRITE_LOAD_CHECKSUM_EN
    do_load(2, 8'h00, "ck_good");
    chk("ck_good_err", 32'(bus.err), 32'd0);
    do_load(2, 8'h05, "ck_bad");
    chk("ck_bad_err", 32'(bus.err), 32'd1);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    chk("ck_err_cleared", 32'(bus.err), 32'd0);
    apply_reset();
`endif

    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
